// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch bus interface.
// Optional feature macro: FETCH_ADEL_EN (misaligned-fetch detection).
package fetch_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_ADDR = 3'd1,
    ST_WAIT_DATA = 3'd2,
    ST_HOLD      = 3'd3,
    ST_DISCARD   = 3'd4
  } fetch_state_t;

  localparam logic [1:0]  SIZE_WORD        = 2'b10;
  localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;

  // Word-align a byte address by clearing the two low bits.
  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_hold_buf.sv
// Holding register for a fetched word that Decode could not take yet.
// load_i captures data_i and marks it valid; clr_i drops the valid bit.
module fetch_hold_buf (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,
  input  logic        clr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        valid_o
);

  logic [31:0] data_d, data_q;
  logic        valid_d, valid_q;

  // Next-value logic: load has priority over clear.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (load_i) begin
      data_d  = data_i;
      valid_d = 1'b1;
    end else if (clr_i) begin
      valid_d = 1'b0;
    end
  end

  // Storage with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= 32'h0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/fetch_sram_if.sv
// Instruction-fetch front end: turns the fetch PC into single-outstanding
// sram-like bus reads, bypasses/holds the returned word for Decode, and
// discards fetches killed by a branch redirect.
// Optional feature macro: FETCH_ADEL_EN (misaligned fetch raises adel_o
// instead of going to the bus).
//
// Bus handshake: inst_req/inst_addr are held stable from the first cycle of
// a request until the cycle inst_addr_ok is seen high (a request is never
// withdrawn, even when flushed); one inst_data_ok then completes the single
// outstanding read. Fetch-side: instr_o is consumed in a cycle where
// instr_valid_o=1 and stall_i=0.
module fetch_sram_if
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_WORD = NOP_WORD_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         fetch_en,
  input  logic [31:0]  pc_i,
  input  logic         stall_i,
  input  logic         flush_i,
  output logic [31:0]  instr_o,
  output logic         instr_valid_o,
  output logic         stall_req_o,
  output logic [31:0]  last_pc_o,
  output logic         adel_o,
  output logic         inst_req,
  output logic         inst_wr,
  output logic [1:0]   inst_size,
  output logic [31:0]  inst_addr,
  output logic [31:0]  inst_wdata,
  input  logic         inst_addr_ok,
  input  logic         inst_data_ok,
  input  logic [31:0]  inst_rdata,
  output fetch_state_t dbg_state_o
);

  fetch_state_t state_d, state_q;
  logic [31:0]  addr_d, addr_q;
  logic [31:0]  last_pc_d, last_pc_q;
  logic         kill_d, kill_q;

  logic         req;
  logic [31:0]  bus_addr;
  logic [31:0]  instr;
  logic         valid;
  logic         hold_load, hold_clr;
  logic [31:0]  hold_din, hold_data;
  logic         hold_vld;
  logic         misaligned;
  logic [31:0]  pc_bus;

`ifdef FETCH_ADEL_EN
  logic adel_d, adel_q;
  assign misaligned = (pc_i[1:0] != 2'b00);
  assign pc_bus     = pc_i;
`else
  assign misaligned = 1'b0;
  assign pc_bus     = word_align(pc_i);
`endif

  fetch_hold_buf u_hold (
    .clk     (clk),
    .rst_n   (rst),
    .load_i  (hold_load),
    .clr_i   (hold_clr),
    .data_i  (hold_din),
    .data_o  (hold_data),
    .valid_o (hold_vld)
  );

  // Next-state and datapath control for the fetch FSM.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    last_pc_d = last_pc_q;
    kill_d    = kill_q;
    req       = 1'b0;
    bus_addr  = addr_q;
    instr     = NOP_WORD;
    valid     = 1'b0;
    hold_load = 1'b0;
    hold_clr  = 1'b0;
    hold_din  = inst_rdata;
`ifdef FETCH_ADEL_EN
    adel_d    = adel_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (fetch_en && !flush_i) begin
          last_pc_d = pc_i;
          kill_d    = 1'b0;
          if (misaligned) begin
            // Faulting fetch never reaches the bus; Decode sees a NOP.
            hold_load = 1'b1;
            hold_din  = NOP_WORD;
            state_d   = ST_HOLD;
`ifdef FETCH_ADEL_EN
            adel_d    = 1'b1;
`endif
          end else begin
            req      = 1'b1;
            bus_addr = pc_bus;
            addr_d   = pc_bus;
            state_d  = inst_addr_ok ? ST_WAIT_DATA : ST_WAIT_ADDR;
`ifdef FETCH_ADEL_EN
            adel_d   = 1'b0;
`endif
          end
        end
      end
      ST_WAIT_ADDR: begin
        req      = 1'b1;
        bus_addr = addr_q;
        kill_d   = kill_q | flush_i;
        if (inst_addr_ok) begin
          state_d = (flush_i || kill_q) ? ST_DISCARD : ST_WAIT_DATA;
        end
      end
      ST_WAIT_DATA: begin
        if (inst_data_ok) begin
          if (flush_i || kill_q) begin
            state_d = ST_IDLE;
          end else begin
            valid = 1'b1;
            instr = inst_rdata;
            if (stall_i) begin
              hold_load = 1'b1;
              state_d   = ST_HOLD;
            end else begin
              state_d   = ST_IDLE;
            end
          end
        end else if (flush_i) begin
          state_d = ST_DISCARD;
        end
      end
      ST_HOLD: begin
        valid = hold_vld;
        instr = hold_data;
        if (flush_i || !stall_i) begin
          hold_clr = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      ST_DISCARD: begin
        if (inst_data_ok) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state, address latch, last PC and sticky kill.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      addr_q    <= 32'h0;
      last_pc_q <= RESET_PC;
      kill_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      last_pc_q <= last_pc_d;
      kill_q    <= kill_d;
    end
  end

`ifdef FETCH_ADEL_EN
  // Remembers that the held word came from a misaligned fetch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) adel_q <= 1'b0;
    else      adel_q <= adel_d;
  end
  assign adel_o = adel_q & valid & (state_q == ST_HOLD);
`else
  assign adel_o = 1'b0;
`endif

  // Combinational outputs are forced quiet while reset is held.
  assign inst_req      = rst & req;
  assign inst_addr     = inst_req ? bus_addr : 32'h0;
  assign inst_wr       = 1'b0;
  assign inst_size     = SIZE_WORD;
  assign inst_wdata    = 32'h0;
  assign instr_o       = instr;
  assign instr_valid_o = valid;
  assign stall_req_o   = rst & fetch_en & ~valid & ~flush_i;
  assign last_pc_o     = last_pc_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_fetch_sram_if.sv
// Directed testbench for fetch_sram_if. Inputs change on the falling edge;
// outputs are checked 1 ns later, well before the next rising edge.
module tb_fetch_sram_if;
  import fetch_pkg::*;

  logic         clk;
  logic         rst;
  logic         fetch_en;
  logic [31:0]  pc_i;
  logic         stall_i;
  logic         flush_i;
  logic [31:0]  instr_o;
  logic         instr_valid_o;
  logic         stall_req_o;
  logic [31:0]  last_pc_o;
  logic         adel_o;
  logic         inst_req;
  logic         inst_wr;
  logic [1:0]   inst_size;
  logic [31:0]  inst_addr;
  logic [31:0]  inst_wdata;
  logic         inst_addr_ok;
  logic         inst_data_ok;
  logic [31:0]  inst_rdata;
  fetch_state_t dbg_state_o;

  int n_checks = 0;
  int n_fail   = 0;
  int proto_err_cnt = 0;

  localparam logic [31:0] NOP = 32'h0000_0000;

  fetch_sram_if dut (
    .clk           (clk),
    .rst           (rst),
    .fetch_en      (fetch_en),
    .pc_i          (pc_i),
    .stall_i       (stall_i),
    .flush_i       (flush_i),
    .instr_o       (instr_o),
    .instr_valid_o (instr_valid_o),
    .stall_req_o   (stall_req_o),
    .last_pc_o     (last_pc_o),
    .adel_o        (adel_o),
    .inst_req      (inst_req),
    .inst_wr       (inst_wr),
    .inst_size     (inst_size),
    .inst_addr     (inst_addr),
    .inst_wdata    (inst_wdata),
    .inst_addr_ok  (inst_addr_ok),
    .inst_data_ok  (inst_data_ok),
    .inst_rdata    (inst_rdata),
    .dbg_state_o   (dbg_state_o)
  );

  // Clock and reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Protocol monitor: data_ok must not arrive when nothing is outstanding.
  always @(posedge clk) begin
    if (rst && inst_data_ok &&
        (dbg_state_o == ST_IDLE || dbg_state_o == ST_HOLD))
      proto_err_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Driver: apply one cycle of inputs on the falling edge, settle 1 ns.
  task automatic cyc(input logic fe, input logic [31:0] pc, input logic st,
                     input logic fl, input logic aok, input logic dok,
                     input logic [31:0] rd);
    @(negedge clk);
    fetch_en = fe; pc_i = pc; stall_i = st; flush_i = fl;
    inst_addr_ok = aok; inst_data_ok = dok; inst_rdata = rd;
    #1;
  endtask

  initial begin
    rst = 1'b0; fetch_en = 1'b0; pc_i = 32'h0; stall_i = 1'b0; flush_i = 1'b0;
    inst_addr_ok = 1'b0; inst_data_ok = 1'b0; inst_rdata = 32'h0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_instr",   instr_o, NOP);
    chk("rst_valid",   32'(instr_valid_o), 32'd0);
    chk("rst_req",     32'(inst_req), 32'd0);
    chk("rst_stall",   32'(stall_req_o), 32'd0);
    chk("rst_last_pc", last_pc_o, 32'hBFC0_0000);
    chk("rst_state",   32'(dbg_state_o), 32'(ST_IDLE));
    chk("rst_size",    32'(inst_size), 32'h2);
    @(negedge clk); rst = 1'b1;

    // 1: addr_ok same cycle, data_ok next cycle
    cyc(1, 32'hBFC0_0000, 0, 0, 1, 0, 32'h0);
    chk("t1_req",    32'(inst_req), 32'd1);
    chk("t1_addr",   inst_addr, 32'hBFC0_0000);
    chk("t1_stall0", 32'(stall_req_o), 32'd1);
    chk("t1_valid0", 32'(instr_valid_o), 32'd0);
    cyc(1, 32'hBFC0_0000, 0, 0, 0, 1, 32'h2408_0001);
    chk("t1_valid1", 32'(instr_valid_o), 32'd1);
    chk("t1_instr",  instr_o, 32'h2408_0001);
    chk("t1_stall1", 32'(stall_req_o), 32'd0);
    chk("t1_req1",   32'(inst_req), 32'd0);
    cyc(0, 32'hBFC0_0004, 0, 0, 0, 0, 32'h0);
    chk("t1_idle",   32'(dbg_state_o), 32'(ST_IDLE));
    chk("t1_nop",    instr_o, NOP);
    chk("t1_lastpc", last_pc_o, 32'hBFC0_0000);

    // 2: addr_ok delayed 3 cycles; pc_i wanders but the bus must not
    cyc(1, 32'hBFC0_0004, 0, 0, 0, 0, 32'h0);
    chk("t2_req_c0",  32'(inst_req), 32'd1);
    chk("t2_addr_c0", inst_addr, 32'hBFC0_0004);
    chk("t2_stall_c0", 32'(stall_req_o), 32'd1);
    for (int i = 1; i < 4; i++) begin
      cyc(1, 32'h1234_5678, 0, 0, (i == 3), 0, 32'h0);
      chk("t2_req",   32'(inst_req), 32'd1);
      chk("t2_addr",  inst_addr, 32'hBFC0_0004);
      chk("t2_stall", 32'(stall_req_o), 32'd1);
      chk("t2_instr", instr_o, NOP);
    end
    cyc(1, 32'h1234_5678, 0, 0, 0, 1, 32'h3C01_0000);
    chk("t2_valid",  32'(instr_valid_o), 32'd1);
    chk("t2_instr",  instr_o, 32'h3C01_0000);
    chk("t2_lastpc", last_pc_o, 32'hBFC0_0004);
    cyc(0, 32'h0, 0, 0, 0, 0, 32'h0);
    chk("t2_idle",   32'(dbg_state_o), 32'(ST_IDLE));

    // 3: data_ok while Decode stalled for 2 cycles
    cyc(1, 32'hBFC0_0008, 0, 0, 1, 0, 32'h0);
    chk("t3_req", 32'(inst_req), 32'd1);
    cyc(1, 32'hBFC0_000C, 1, 0, 0, 1, 32'h8C09_0004);
    chk("t3_byp_valid", 32'(instr_valid_o), 32'd1);
    chk("t3_byp_instr", instr_o, 32'h8C09_0004);
    cyc(1, 32'hBFC0_000C, 1, 0, 0, 0, 32'hDEAD_BEEF);
    chk("t3_hold_state", 32'(dbg_state_o), 32'(ST_HOLD));
    chk("t3_hold_valid", 32'(instr_valid_o), 32'd1);
    chk("t3_hold_instr", instr_o, 32'h8C09_0004);
    chk("t3_hold_stall", 32'(stall_req_o), 32'd0);
    chk("t3_hold_req",   32'(inst_req), 32'd0);
    cyc(1, 32'hBFC0_000C, 0, 0, 0, 0, 32'hDEAD_BEEF);
    chk("t3_rel_valid", 32'(instr_valid_o), 32'd1);
    chk("t3_rel_instr", instr_o, 32'h8C09_0004);
    cyc(0, 32'h0, 0, 0, 0, 0, 32'h0);
    chk("t3_idle",  32'(dbg_state_o), 32'(ST_IDLE));
    chk("t3_valid", 32'(instr_valid_o), 32'd0);

    // 4: flush during WAIT_DATA, data_ok two cycles later
    cyc(1, 32'hBFC0_000C, 0, 0, 1, 0, 32'h0);
    cyc(1, 32'hBFC0_000C, 0, 1, 0, 0, 32'h0);
    chk("t4_fl_valid", 32'(instr_valid_o), 32'd0);
    chk("t4_fl_stall", 32'(stall_req_o), 32'd0);
    cyc(1, 32'hBFC0_0100, 0, 0, 0, 0, 32'h0);
    chk("t4_disc_state", 32'(dbg_state_o), 32'(ST_DISCARD));
    chk("t4_disc_req",   32'(inst_req), 32'd0);
    chk("t4_disc_stall", 32'(stall_req_o), 32'd1);
    cyc(1, 32'hBFC0_0100, 0, 0, 0, 1, 32'h1111_1111);
    chk("t4_drop_valid", 32'(instr_valid_o), 32'd0);
    chk("t4_drop_instr", instr_o, NOP);
    cyc(1, 32'hBFC0_0100, 0, 0, 1, 0, 32'h0);
    chk("t4_new_req",  32'(inst_req), 32'd1);
    chk("t4_new_addr", inst_addr, 32'hBFC0_0100);
    cyc(1, 32'hBFC0_0100, 0, 0, 0, 1, 32'h0000_0021);
    chk("t4_new_valid", 32'(instr_valid_o), 32'd1);
    chk("t4_new_instr", instr_o, 32'h0000_0021);

    // 5: flush during WAIT_ADDR
    cyc(1, 32'hBFC0_0200, 0, 0, 0, 0, 32'h0);
    chk("t5_req0", 32'(inst_req), 32'd1);
    cyc(1, 32'hBFC0_0200, 0, 1, 0, 0, 32'h0);
    chk("t5_req1",  32'(inst_req), 32'd1);
    chk("t5_addr1", inst_addr, 32'hBFC0_0200);
    cyc(0, 32'hBFC0_0300, 0, 0, 1, 0, 32'h0);
    chk("t5_req2",  32'(inst_req), 32'd1);
    chk("t5_addr2", inst_addr, 32'hBFC0_0200);
    cyc(0, 32'hBFC0_0300, 0, 0, 0, 1, 32'h2222_2222);
    chk("t5_disc_state", 32'(dbg_state_o), 32'(ST_DISCARD));
    chk("t5_disc_valid", 32'(instr_valid_o), 32'd0);
    cyc(0, 32'hBFC0_0300, 0, 0, 0, 0, 32'h0);
    chk("t5_idle",  32'(dbg_state_o), 32'(ST_IDLE));
    chk("t5_valid", 32'(instr_valid_o), 32'd0);

    // 6: reset asserted in WAIT_DATA
    cyc(1, 32'hBFC0_0300, 0, 0, 1, 0, 32'h0);
    cyc(1, 32'hBFC0_0300, 0, 0, 0, 0, 32'h0);
    chk("t6_wd_state", 32'(dbg_state_o), 32'(ST_WAIT_DATA));
    @(negedge clk); rst = 1'b0; #1;
    chk("t6_rst_req",    32'(inst_req), 32'd0);
    chk("t6_rst_addr",   inst_addr, 32'h0);
    chk("t6_rst_stall",  32'(stall_req_o), 32'd0);
    chk("t6_rst_instr",  instr_o, NOP);
    chk("t6_rst_state",  32'(dbg_state_o), 32'(ST_IDLE));
    chk("t6_rst_lastpc", last_pc_o, 32'hBFC0_0000);
    @(negedge clk);
    rst = 1'b1; fetch_en = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'h3333_3333;
    #1;
    chk("t6_stray_valid", 32'(instr_valid_o), 32'd0);
    chk("t6_stray_instr", instr_o, NOP);
    cyc(0, 32'h0, 0, 0, 0, 0, 32'h0);
    chk("t6_post_state", 32'(dbg_state_o), 32'(ST_IDLE));
    chk("t6_post_valid", 32'(instr_valid_o), 32'd0);

`ifdef FETCH_ADEL_EN
    // Misaligned fetch is reported, never sent to the bus
    cyc(1, 32'hBFC0_0002, 0, 0, 0, 0, 32'h0);
    chk("adel_req0", 32'(inst_req), 32'd0);
    cyc(1, 32'hBFC0_0002, 0, 0, 0, 0, 32'h0);
    chk("adel_req1",  32'(inst_req), 32'd0);
    chk("adel_flag",  32'(adel_o), 32'd1);
    chk("adel_valid", 32'(instr_valid_o), 32'd1);
    chk("adel_instr", instr_o, NOP);
    cyc(0, 32'h0, 0, 0, 0, 0, 32'h0);
    chk("adel_clr", 32'(adel_o), 32'd0);
`else
    // Low address bits are dropped on the bus; adel_o stays low
    cyc(1, 32'hBFC0_0402, 0, 0, 1, 0, 32'h0);
    chk("align_addr", inst_addr, 32'hBFC0_0400);
    chk("align_adel", 32'(adel_o), 32'd0);
    cyc(0, 32'h0, 0, 0, 0, 1, 32'h5555_5555);
    chk("align_instr",  instr_o, 32'h5555_5555);
    chk("align_lastpc", last_pc_o, 32'hBFC0_0402);
    cyc(0, 32'h0, 0, 0, 0, 0, 32'h0);
`endif

    // Exactly one stray data_ok was presented (after reset release in test 6)
    chk("proto_err_cnt", 32'(proto_err_cnt), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
